key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 14 +
 rtl/key_debounce_chan.sv | 113 +++++++++++
 rtl/key_debounce.sv | 48 ++++
 tb/tb_key_debounce.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and default timing constants for the key debouncer.
// KEY_DEBOUNCE_LONGPRESS_EN (optional macro) enables the long-press hold counter.
package key_debounce_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } chan_state_e;

  // 10 ms debounce and 1 s long-press at a 50 MHz clock
  localparam int unsigned DB_CYCLES_DEF = 500000;
  localparam int unsigned LP_CYCLES_DEF = 50000000;

endpackage

// File: rtl/key_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, STABLE/SETTLING state machine,
// press strobe, and (with KEY_DEBOUNCE_LONGPRESS_EN) a long-press hold counter.
// Ports:
//   clk, reset_n  : clock, async active-low reset
//   raw           : raw active-low key input (asynchronous)
//   db            : debounced level (active-low)
//   press         : one-cycle strobe when db has just fallen
//   long_press    : one-cycle strobe after a long continuous press (0 when disabled)
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  , parameter int unsigned LP_CYCLES = LP_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db,
  output logic press,
  output logic long_press
);

  localparam int CW = $clog2(DB_CYCLES);
  // The state machine spends DB_CYCLES edges on a differing level, the first
  // of them in STABLE; the accepting edge is the one that would bring the
  // count to DB_CYCLES-1, which keeps key_raw->db at exactly 2+DB_CYCLES edges.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 2);

  logic [1:0]    sync;
  logic          sample;
  chan_state_e   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          db_nx, press_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= 2'b11;
    else          sync <= {sync[0], raw};
  end

  assign sample = sync[1];

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    db_nx    = db;
    press_nx = 1'b0;
    unique case (state)
      STABLE: begin
        if (sample != db) state_nx = SETTLING;
      end
      SETTLING: begin
        if (sample == db) begin
          state_nx = STABLE;                  // bounced back, drop the attempt
        end else if (cnt == CNT_LAST) begin
          state_nx = STABLE;
          db_nx    = sample;
          press_nx = ~sample;                 // strobe on acceptance of 0 only
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = STABLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= STABLE;
      cnt   <= '0;
      db    <= 1'b1;
      press <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      db    <= db_nx;
      press <= press_nx;
    end
  end

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  localparam int HW = $clog2(LP_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LP_CYCLES - 1);

  logic [HW-1:0] hold;
  logic          fired;

  // hold is 0 on the edge db falls and counts up while db stays low; the
  // strobe follows the cycle it saturates, and fired keeps it to one per press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold       <= '0;
      fired      <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (db) begin
        hold  <= '0;
        fired <= 1'b0;
      end else if (hold != HOLD_LAST) begin
        hold <= hold + 1'b1;
      end else if (!fired) begin
        long_press <= 1'b1;
        fired      <= 1'b1;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: NUM_KEYS independent channels, all registered outputs.
// Optional macro KEY_DEBOUNCE_LONGPRESS_EN adds per-key long-press strobes;
// without it long_press is tied to 0.
// Ports:
//   clk, reset_n : single clock, async active-low reset
//   key_raw      : raw active-low pushbuttons (0 = pressed)
//   key_db       : debounced levels, same polarity as key_raw
//   press_pulse  : per-key one-cycle strobe on accepted press
//   long_press   : per-key one-cycle strobe after LP_CYCLES of held press
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned NUM_KEYS  = 2,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned LP_CYCLES = LP_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_db,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] long_press
);

  if (DB_CYCLES < 2 || DB_CYCLES > 32'd16777215) begin : g_bad_db
    $error("key_debounce: DB_CYCLES must be within 2..2^24-1");
  end
  if (LP_CYCLES < 2) begin : g_bad_lp
    $error("key_debounce: LP_CYCLES must be at least 2");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DB_CYCLES(DB_CYCLES)
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
      , .LP_CYCLES(LP_CYCLES)
`endif
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw        (key_raw[i]),
      .db         (key_db[i]),
      .press      (press_pulse[i]),
      .long_press (long_press[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce (NUM_KEYS=2, DB_CYCLES=4, LP_CYCLES=16).
// The reference model works from a raw-sample history: a level is accepted
// once the last DB samples (raw delayed two edges) all differ from the
// current debounced level. Expected outputs are queued per edge and popped
// by an independent monitor on the falling edge.
module tb_key_debounce;
  localparam int NK = 2;
  localparam int DB = 4;
  localparam int LP = 16;

  typedef struct packed {
    logic [NK-1:0] db;
    logic [NK-1:0] press;
    logic [NK-1:0] lp;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NK-1:0] key_raw = '1;
  logic [NK-1:0] key_db, press_pulse, long_press;

  always #5 clk = ~clk;

  key_debounce #(.NUM_KEYS(NK), .DB_CYCLES(DB), .LP_CYCLES(LP)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_raw     (key_raw),
    .key_db      (key_db),
    .press_pulse (press_pulse),
    .long_press  (long_press)
  );

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;

  // reference model state
  logic [NK-1:0] d1 = '1, d2 = '1, m_db = '1;
  logic [15:0]   hist[NK];
  int            low_cnt[NK];

  task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // one rising edge of the reference model
  task automatic model_edge();
    exp_t e;
    e = '0;
    for (int k = 0; k < NK; k++) begin
      logic s;
      bit   all_diff;
      if (!reset_n) begin
        d1[k] = 1'b1; d2[k] = 1'b1; m_db[k] = 1'b1;
        hist[k] = '1; low_cnt[k] = 0;
      end else begin
        s = d2[k]; d2[k] = d1[k]; d1[k] = key_raw[k];
        hist[k] = {hist[k][14:0], s};
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) if (hist[k][j] == m_db[k]) all_diff = 1'b0;
        if (all_diff) begin
          m_db[k] = s;
          e.press[k] = ~s;
          low_cnt[k] = 0;
        end else if (m_db[k] == 1'b0) begin
          low_cnt[k]++;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
          if (low_cnt[k] == LP) e.lp[k] = 1'b1;
`endif
        end else begin
          low_cnt[k] = 0;
        end
      end
      e.db[k] = m_db[k];
    end
    sb.push_back(e);
  endtask

  task automatic drive(input logic [NK-1:0] raw, input logic rst, input int n);
    repeat (n) begin
      @(negedge clk); #1;
      key_raw = raw;
      reset_n = rst;
      @(posedge clk);
      model_edge();
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("key_db", key_db, mon_e.db);
      check("press_pulse", press_pulse, mon_e.press);
      check("long_press", long_press, mon_e.lp);
    end
  end

  initial begin
    logic [NK-1:0] r;
    logic          rst;
    int            n;
    for (int k = 0; k < NK; k++) begin hist[k] = '1; low_cnt[k] = 0; end

    drive(2'b11, 1'b0, 3);
    drive(2'b11, 1'b1, 4);
    // clean press/release of key 0
    drive(2'b10, 1'b1, 12);
    drive(2'b11, 1'b1, 12);
    // bounce every 2 cycles, then settle pressed
    drive(2'b10, 1'b1, 2); drive(2'b11, 1'b1, 2);
    drive(2'b10, 1'b1, 2); drive(2'b11, 1'b1, 2);
    drive(2'b10, 1'b1, 12);
    drive(2'b11, 1'b1, 12);
    // both keys together
    drive(2'b00, 1'b1, 20);
    drive(2'b11, 1'b1, 12);
    // reset mid-settling with key held
    drive(2'b10, 1'b1, 5);
    drive(2'b10, 1'b0, 3);
    drive(2'b10, 1'b1, 12);
    drive(2'b11, 1'b1, 12);
    // long hold on key 1
    drive(2'b01, 1'b1, 40);
    drive(2'b11, 1'b1, 12);
    // random levels and hold times, occasional reset
    repeat (60) begin
      r   = NK'($urandom_range(0, 3));
      n   = $urandom_range(1, 24);
      rst = ($urandom_range(0, 19) != 0);
      drive(r, rst, (rst ? n : 2));
    end
    drive(2'b11, 1'b1, 10);

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
